rom_id_check: RTL and testbench

//  Downstream consumer of the 64-bit serial-in shift register in the reader path.

---
 rtl/rom_id_check_if.sv | 24 ++
 rtl/rom_id_check.sv | 124 ++++++++++++
 tb/tb_rom_id_check.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rom_id_check_if.sv
// Handshake/bus bundle between the 64-bit ID shift register, rom_id_check and the ID consumer.
interface rom_id_check_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] din;
    logic             done;
    logic             sr_clr;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             ready;
    logic             crc_ok;
    logic             busy;
    logic             crc_err;

    modport slave (
        input  din, done, ready,
        output sr_clr, dout, valid, crc_ok, busy, crc_err
    );

    modport master (
        output din, done, ready,
        input  sr_clr, dout, valid, crc_ok, busy, crc_err
    );
endinterface

// File: rtl/rom_id_check.sv
// Latches a 64-bit 1-Wire ROM ID, restores wire bit order, checks Dallas CRC-8 bit-serially.
// Optional ROM_CRC_DROP_EN: bad-CRC words are dropped with a one-cycle crc_err pulse.
module rom_id_check #(
    parameter int unsigned WIDTH    = 64,
    parameter logic [7:0]  CRC_POLY = 8'h8C
) (
    input  logic           clk,
    input  logic           clr,
    rom_id_check_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned CRC_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_word;
    logic [CRC_W-1:0]   r_crc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sr_clr;
    logic               r_valid;
    logic               r_crc_ok;
    logic               r_busy;

    logic [WIDTH-1:0]   w_rev;
    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_next;
    logic               w_last;

    // First received bit sits at din[WIDTH-1]; wire order puts it at bit 0.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_rev[i] = bus.din[int'(WIDTH) - 1 - i];
        end
    end

    assign w_fb       = r_crc[0] ^ r_word[r_cnt];
    assign w_crc_next = (r_crc >> 1) ^ (w_fb ? CRC_POLY : CRC_W'(0));
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ROM_CRC_DROP_EN
    logic r_crc_err;
    assign bus.crc_err = r_crc_err;
`else
    assign bus.crc_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_word   <= '0;
            r_crc    <= '0;
            r_cnt    <= '0;
            r_sr_clr <= 1'b0;
            r_valid  <= 1'b0;
            r_crc_ok <= 1'b0;
            r_busy   <= 1'b0;
`ifdef ROM_CRC_DROP_EN
            r_crc_err <= 1'b0;
`endif
        end else begin
            r_sr_clr <= 1'b0;
`ifdef ROM_CRC_DROP_EN
            r_crc_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.done) begin
                        r_word   <= w_rev;
                        r_crc    <= '0;
                        r_cnt    <= '0;
                        r_sr_clr <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_crc <= w_crc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
`ifdef ROM_CRC_DROP_EN
                        if (w_crc_next != '0) begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_crc_ok  <= 1'b0;
                            r_crc_err <= 1'b1;
                        end else begin
                            r_state  <= S_PRESENT;
                            r_valid  <= 1'b1;
                            r_crc_ok <= 1'b1;
                        end
`else
                        r_state  <= S_PRESENT;
                        r_valid  <= 1'b1;
                        r_crc_ok <= (w_crc_next == '0);
`endif
                    end
                end
                S_PRESENT: begin
                    // Output held until the consumer takes it; a waiting word is caught in IDLE.
                    if (bus.ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sr_clr = r_sr_clr;
    assign bus.dout   = r_word;
    assign bus.valid  = r_valid;
    assign bus.crc_ok = r_crc_ok;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_rom_id_check.sv
// Directed bench for rom_id_check: capture timing, CRC verdicts, stall, async clear, back-to-back spacing.
module tb_rom_id_check;
    localparam logic [63:0] W_GOOD = 64'hA200000001B81C02;
    localparam logic [63:0] W_BAD  = W_GOOD ^ (64'd1 << 20);
    localparam logic [63:0] W_ZERO = 64'h0;

    logic clk;
    logic clr;
    int   n_pass;
    int   n_chk;
    int   caps [8];
    int   ncap;
    bit   seen_valid;

    rom_id_check_if #(.WIDTH(64)) bus ();

    rom_id_check #(.WIDTH(64), .CRC_POLY(8'h8C)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] bitrev(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63 - i] = w[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // From an IDLE negedge: present word, capture, confirm single sr_clr pulse; ends after edge E1.
    task automatic start_word(input logic [63:0] w);
        bus.din   = bitrev(w);
        bus.done  = 1'b1;
        bus.ready = 1'b0;
        @(negedge clk);
        check("sr_clr_pulse", 64'(bus.sr_clr), 64'd1);
        check("busy_calc", 64'(bus.busy), 64'd1);
        bus.done = 1'b0;
        @(negedge clk);
        check("sr_clr_single", 64'(bus.sr_clr), 64'd0);
    endtask

    // Runs to the negedge after E64 (valid should have just risen).
    task automatic finish_calc();
        repeat (62) @(negedge clk);
        check("valid_not_early", 64'(bus.valid), 64'd0);
        @(negedge clk);
    endtask

    task automatic transfer();
        bus.ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 64'(bus.valid), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        bus.ready = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        clr    = 1'b1;
        bus.din   = '0;
        bus.done  = 1'b0;
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sr_clr", 64'(bus.sr_clr), 64'd0);
        check("rst_dout", bus.dout, 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_crc_ok", 64'(bus.crc_ok), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_crc_err", 64'(bus.crc_err), 64'd0);
        clr = 1'b0;
        @(negedge clk);

        // Known-good Maxim example ID
        start_word(W_GOOD);
        finish_calc();
        check("t1_valid", 64'(bus.valid), 64'd1);
        check("t1_dout", bus.dout, W_GOOD);
        check("t1_crc_ok", 64'(bus.crc_ok), 64'd1);
        transfer();

        // Single flipped bit
        start_word(W_BAD);
        finish_calc();
`ifdef ROM_CRC_DROP_EN
        check("t2_valid_dropped", 64'(bus.valid), 64'd0);
        check("t2_crc_err", 64'(bus.crc_err), 64'd1);
        check("t2_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("t2_crc_err_once", 64'(bus.crc_err), 64'd0);
        check("t2_valid_low", 64'(bus.valid), 64'd0);
`else
        check("t2_valid", 64'(bus.valid), 64'd1);
        check("t2_crc_ok", 64'(bus.crc_ok), 64'd0);
        check("t2_dout", bus.dout, W_BAD);
        check("t2_crc_err", 64'(bus.crc_err), 64'd0);
        transfer();
`endif

        // Stall with a second word waiting
        start_word(W_GOOD);
        finish_calc();
        bus.din  = bitrev(W_ZERO);
        bus.done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("t3_valid_hold", 64'(bus.valid), 64'd1);
            check("t3_dout_hold", bus.dout, W_GOOD);
            check("t3_no_sr_clr", 64'(bus.sr_clr), 64'd0);
            @(negedge clk);
        end
        bus.ready = 1'b1;
        @(negedge clk);
        check("t3_valid_drop", 64'(bus.valid), 64'd0);
        check("t3_idle_sr_clr", 64'(bus.sr_clr), 64'd0);
        bus.ready = 1'b0;
        @(negedge clk);
        check("t3_second_capture", 64'(bus.sr_clr), 64'd1);
        check("t3_second_busy", 64'(bus.busy), 64'd1);
        bus.done = 1'b0;
        @(negedge clk);
        check("t3_second_single", 64'(bus.sr_clr), 64'd0);
        finish_calc();
        check("t3_second_dout", bus.dout, W_ZERO);
        check("t3_second_ok", 64'(bus.crc_ok), 64'd1);
        transfer();

        // Async clear mid-CRC (after cnt reaches 30)
        start_word(W_GOOD);
        repeat (29) @(negedge clk);
        clr = 1'b1;
        #1;
        check("t4_dout", bus.dout, 64'd0);
        check("t4_valid", 64'(bus.valid), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_sr_clr", 64'(bus.sr_clr), 64'd0);
        check("t4_crc_ok", 64'(bus.crc_ok), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (70) begin
            @(negedge clk);
            check("t4_quiet", 64'({bus.valid, bus.sr_clr}), 64'd0);
        end
        start_word(W_GOOD);
        finish_calc();
        check("t4_after_valid", 64'(bus.valid), 64'd1);
        check("t4_after_ok", 64'(bus.crc_ok), 64'd1);
        check("t4_after_dout", bus.dout, W_GOOD);
        transfer();

        // All-zero word, back-to-back captures
        bus.din    = bitrev(W_ZERO);
        bus.done   = 1'b1;
        bus.ready  = 1'b1;
        ncap       = 0;
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) caps[k] = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.sr_clr && ncap < 8) begin
                caps[ncap] = c;
                ncap++;
            end
            if (bus.valid && !seen_valid) begin
                seen_valid = 1'b1;
                check("t5_dout", bus.dout, W_ZERO);
                check("t5_crc_ok", 64'(bus.crc_ok), 64'd1);
            end
        end
        check("t5_valid_seen", 64'(seen_valid), 64'd1);
        check("t5_cap_count", 64'(ncap >= 3), 64'd1);
        check("t5_spacing_1", 64'(caps[1] - caps[0]), 64'd66);
        check("t5_spacing_2", 64'(caps[2] - caps[1]), 64'd66);
        bus.done  = 1'b0;
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
